// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states
// and a helper that identifies the ops which update the stored carry flag.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL1 = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR1 = 4'b0111;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_ADDC = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_t;

  // Arithmetic and shift ops leave their carry behind for a later ADDC;
  // logic ops, MUL and illegal codes must not disturb it.
  function automatic logic op_updates_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDC) ||
           (op == OP_SHL1) || (op == OP_SHR1);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// WIDTH-parametrised shift-add unsigned multiplier. A start pulse loads the
// operands; one partial product is accumulated per clock. 'last' is high
// during the final iteration and 'product' then already shows the finished
// result, so the owner can register it on that same edge.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  logic               busy_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;

  // Partial product: the shifted multiplicand gated by the current multiplier LSB.
  for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
    assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
  end

  assign acc_next = acc_reg + addend;
  assign last     = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
  assign product  = acc_next;

  // Iteration state: load on start, then shift and accumulate until the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      cnt_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      acc_reg    <= '0;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
      if (last) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU. Single-cycle ops are computed by a
// combinational function and registered on acceptance; MUL is handed to a
// shift-add multiplier and its product registered on the final iteration.
// Results are held in HOLD until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             err;
  } result_t;

  // Every op except MUL. Codes outside the table (MUL never reaches here)
  // return an all-zero result with only err set.
  function automatic result_t exec_single(input logic [3:0]       op,
                                          input logic [WIDTH-1:0] x,
                                          input logic [WIDTH-1:0] y,
                                          input logic             cin);
    result_t      r;
    logic [WIDTH:0] wide;
    r    = '0;
    wide = '0;
    case (op)
      OP_ADD, OP_ADDC: begin
        wide    = {1'b0, x} + {1'b0, y} +
                  ((op == OP_ADDC) ? {{WIDTH{1'b0}}, cin} : '0);
        r.res   = wide[WIDTH-1:0];
        r.carry = wide[WIDTH];
        r.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (r.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, x} - {1'b0, y};
        r.res   = wide[WIDTH-1:0];
        r.carry = wide[WIDTH];
        r.ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (r.res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND:  r.res = x & y;
      OP_OR:   r.res = x | y;
      OP_XOR:  r.res = x ^ y;
      OP_NOT:  r.res = ~x;
      OP_SHL1: begin
        r.res   = {x[WIDTH-2:0], 1'b0};
        r.carry = x[WIDTH-1];
      end
      OP_SHR1: begin
        r.res   = {1'b0, x[WIDTH-1:1]};
        r.carry = x[0];
      end
      default: r.err = 1'b1;
    endcase
    if (!r.err) begin
      r.zero = (r.res == '0);
      r.neg  = r.res[WIDTH-1];
    end
    return r;
  endfunction

  alu_state_t         state_reg;
  alu_state_t         state_next;
  logic               accept;
  logic               is_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;
  result_t            single_res;

  logic [WIDTH-1:0]   alu_out_reg;
  logic [WIDTH-1:0]   alu_out_hi_reg;
  logic               carry_reg;
  logic               zero_reg;
  logic               neg_reg;
  logic               ovf_reg;
  logic               err_reg;
  logic               c_flag_reg;

  assign accept     = in_valid && in_ready;
  assign is_mul     = (alu_op == OP_MUL);
  assign single_res = exec_single(alu_op, a, b, c_flag_reg);

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .last    (mul_last),
    .product (mul_product)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: accepted ops go to MUL or HOLD; HOLD drains to IDLE when nothing follows.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = is_mul ? ST_MUL : ST_HOLD;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            state_next = is_mul ? ST_MUL : ST_HOLD;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs: HOLD only takes a new op when its result is being consumed.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      ST_IDLE: in_ready = 1'b1;
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Result and flag registers plus the stored carry; accept and mul_last never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_reg    <= '0;
      alu_out_hi_reg <= '0;
      carry_reg      <= 1'b0;
      zero_reg       <= 1'b0;
      neg_reg        <= 1'b0;
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
      c_flag_reg     <= 1'b0;
    end else if (accept && !is_mul) begin
      alu_out_reg    <= single_res.res;
      alu_out_hi_reg <= '0;
      carry_reg      <= single_res.carry;
      zero_reg       <= single_res.zero;
      neg_reg        <= single_res.neg;
      ovf_reg        <= single_res.ovf;
      err_reg        <= single_res.err;
      if (op_updates_carry(alu_op)) begin
        c_flag_reg <= single_res.carry;
      end
    end else if (mul_last) begin
      alu_out_reg    <= mul_product[WIDTH-1:0];
      alu_out_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
      carry_reg      <= 1'b0;
      zero_reg       <= (mul_product == '0);
      neg_reg        <= mul_product[2*WIDTH-1];
      ovf_reg        <= 1'b0;
      err_reg        <= 1'b0;
    end
  end

  assign alu_out    = alu_out_reg;
  assign alu_out_hi = alu_out_hi_reg;
  assign carry      = carry_reg;
  assign zero       = zero_reg;
  assign neg        = neg_reg;
  assign ovf        = ovf_reg;
  assign err        = err_reg;

endmodule
